// File: rtl/branch_predictor_if.sv
// Bundle of fetch-side lookup, resolve-side update and statistics signals
// shared between the branch predictor and whatever drives it.
interface branch_predictor_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic [XLEN-1:0]  pc_in;
  logic             predict_taken;
  logic [XLEN-1:0]  predict_target;
  logic             update_valid;
  logic [XLEN-1:0]  update_pc;
  logic             update_taken;
  logic [XLEN-1:0]  update_target;
  logic             update_mispredict;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  // Handshake: there is no back-pressure. update_valid qualifies the update_*
  // fields for exactly one rising edge; when it is low those fields are ignored.
  // pc_in is looked up combinationally every cycle.
  modport master (
    output pc_in, update_valid, update_pc, update_taken, update_target,
           update_mispredict,
    input  predict_taken, predict_target, branch_count, mispredict_count
  );

  modport slave (
    input  pc_in, update_valid, update_pc, update_taken, update_target,
           update_mispredict,
    output predict_taken, predict_target, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with a 2-bit saturating direction
// counter per entry, plus saturating resolved/mispredicted branch counters.
// Lookup is combinational on pc_in; updates land on the next rising edge,
// so a same-cycle lookup always sees the pre-update entry.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int XLEN    = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  branch_predictor_if.slave bus
);
  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  // Entry storage
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [TAG_W-1:0]   tag_d [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];
  logic [XLEN-1:0]    tgt_d [ENTRIES];
  logic [1:0]         cnt_q [ENTRIES];
  logic [1:0]         cnt_d [ENTRIES];

  // Statistics
  logic [CNT_W-1:0] branch_count_q, branch_count_d;
  logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

  // Lookup side
  logic [IDX-1:0]   lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             lk_taken;

  // Update side
  logic [IDX-1:0]   up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  // Word-alignment bits of the PCs carry no information for this structure.
  logic unused_pc_low;
  assign unused_pc_low = ^{bus.pc_in[1:0], bus.update_pc[1:0]};

  // Combinational prediction for the fetch PC from the current entry contents
  always_comb begin
    lk_idx   = bus.pc_in[IDX+1:2];
    lk_tag   = bus.pc_in[XLEN-1:IDX+2];
    lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_taken = lk_hit && cnt_q[lk_idx][1];
    bus.predict_taken  = lk_taken;
    bus.predict_target = lk_taken ? tgt_q[lk_idx] : bus.pc_in + XLEN'(4);
  end

  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

  // Next entry contents and statistics from the resolved branch, if any
  always_comb begin
    valid_d            = valid_q;
    tag_d              = tag_q;
    tgt_d              = tgt_q;
    cnt_d              = cnt_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    up_idx             = bus.update_pc[IDX+1:2];
    up_tag             = bus.update_pc[XLEN-1:IDX+2];
    up_hit             = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    if (bus.update_valid) begin
      if (up_hit) begin
        if (bus.update_taken) begin
          cnt_d[up_idx] = (cnt_q[up_idx] == 2'b11) ? 2'b11 : cnt_q[up_idx] + 2'b01;
          tgt_d[up_idx] = bus.update_target;
        end else begin
          cnt_d[up_idx] = (cnt_q[up_idx] == 2'b00) ? 2'b00 : cnt_q[up_idx] - 2'b01;
        end
      end else if (bus.update_taken) begin
        // A not-taken miss is never worth an entry; only taken misses allocate.
        valid_d[up_idx] = 1'b1;
        tag_d[up_idx]   = up_tag;
        tgt_d[up_idx]   = bus.update_target;
        cnt_d[up_idx]   = 2'b10;
      end

      if (branch_count_q != '1) begin
        branch_count_d = branch_count_q + CNT_W'(1);
      end
      if (bus.update_mispredict && (mispredict_count_q != '1)) begin
        mispredict_count_d = mispredict_count_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset clears everything immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q            <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      valid_q            <= valid_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= tag_d[i];
        tgt_q[i] <= tgt_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a behavioural model that remembers the full PC,
// an integer strength and target per slot, a per-cycle compare process, and
// a queue of hand-computed expectations checked on selected cycles.
module tb_branch_predictor;
  localparam int ENTRIES = 16;
  localparam int XLEN    = 32;
  localparam int CNT_W   = 16;
  localparam int W       = 1 + XLEN + CNT_W + CNT_W;

  logic clock;
  logic reset;
  logic check_en;

  int checks;
  int errors;

  logic [W-1:0] exp_q[$];

  branch_predictor_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  branch_predictor #(.ENTRIES(ENTRIES), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- behavioural model ----------------
  bit              m_valid [ENTRIES];
  logic [XLEN-1:0] m_pc    [ENTRIES];
  logic [XLEN-1:0] m_tgt   [ENTRIES];
  int              m_str   [ENTRIES];
  int              m_bc;
  int              m_mc;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 0;
        m_pc[i]    = '0;
        m_tgt[i]   = '0;
        m_str[i]   = 0;
      end
      m_bc = 0;
      m_mc = 0;
    end else if (bus.update_valid) begin
      int  i;
      bit  hit;
      i   = int'((bus.update_pc >> 2) % ENTRIES);
      hit = m_valid[i] && ((m_pc[i] >> 2) == (bus.update_pc >> 2));
      if (hit && bus.update_taken) begin
        m_str[i] = (m_str[i] < 3) ? m_str[i] + 1 : 3;
        m_tgt[i] = bus.update_target;
      end else if (hit) begin
        m_str[i] = (m_str[i] > 0) ? m_str[i] - 1 : 0;
      end else if (bus.update_taken) begin
        m_valid[i] = 1;
        m_pc[i]    = bus.update_pc;
        m_tgt[i]   = bus.update_target;
        m_str[i]   = 2;
      end
      if (m_bc < 65535) m_bc = m_bc + 1;
      if (bus.update_mispredict && m_mc < 65535) m_mc = m_mc + 1;
    end
  end

  // ---------------- compare process ----------------
  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      int              i;
      bit              e_taken;
      logic [XLEN-1:0] e_tgt;
      logic [W-1:0]    lit;
      i       = int'((bus.pc_in >> 2) % ENTRIES);
      e_taken = m_valid[i] && ((m_pc[i] >> 2) == (bus.pc_in >> 2)) && (m_str[i] >= 2);
      e_tgt   = e_taken ? m_tgt[i] : bus.pc_in + 32'd4;
      chk("model_taken", {31'd0, bus.predict_taken}, {31'd0, e_taken});
      chk("model_target", bus.predict_target, e_tgt);
      chk("model_branch_count", {16'd0, bus.branch_count}, m_bc[XLEN-1:0]);
      chk("model_mispredict_count", {16'd0, bus.mispredict_count}, m_mc[XLEN-1:0]);
      if (exp_q.size() > 0) begin
        lit = exp_q.pop_front();
        chk("lit_taken", {31'd0, bus.predict_taken}, {31'd0, lit[W-1]});
        chk("lit_target", bus.predict_target, lit[W-2 -: XLEN]);
        chk("lit_branch_count", {16'd0, bus.branch_count}, {16'd0, lit[2*CNT_W-1 -: CNT_W]});
        chk("lit_mispredict_count", {16'd0, bus.mispredict_count}, {16'd0, lit[CNT_W-1:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [XLEN-1:0] pc, input logic uv, input logic [XLEN-1:0] upc,
                       input logic ut, input logic [XLEN-1:0] utgt, input logic um);
    @(posedge clock);
    #2;
    bus.pc_in             = pc;
    bus.update_valid      = uv;
    bus.update_pc         = upc;
    bus.update_taken      = ut;
    bus.update_target     = utgt;
    bus.update_mispredict = um;
  endtask

  task automatic idle(input logic [XLEN-1:0] pc);
    drive(pc, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  // Expected outputs for the current cycle, checked at its falling edge
  task automatic push_lit(input logic t, input logic [XLEN-1:0] tgt,
                          input logic [CNT_W-1:0] bc, input logic [CNT_W-1:0] mc);
    exp_q.push_back({t, tgt, bc, mc});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks   = 0;
    errors   = 0;
    check_en = 1'b0;
    reset    = 1'b1;
    bus.pc_in             = 32'h40;
    bus.update_valid      = 1'b0;
    bus.update_pc         = '0;
    bus.update_taken      = 1'b0;
    bus.update_target     = '0;
    bus.update_mispredict = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    reset    = 1'b0;
    check_en = 1'b1;

    // Reset state
    idle(32'h40);                                 push_lit(0, 32'h44, 0, 0);
    // Allocate 0x40; same-cycle lookup still sees the old (empty) entry
    drive(32'h40, 1, 32'h40, 1, 32'h100, 0);     push_lit(0, 32'h44, 0, 0);
    idle(32'h40);                                 push_lit(1, 32'h100, 1, 0);
    // Two not-taken updates walk the counter 10 -> 01 -> 00
    drive(32'h40, 1, 32'h40, 0, 32'h0, 1);       push_lit(1, 32'h100, 1, 0);
    drive(32'h40, 1, 32'h40, 0, 32'h0, 0);       push_lit(0, 32'h44, 2, 1);
    idle(32'h40);                                 push_lit(0, 32'h44, 3, 1);
    // Alias on index 0: 0x80 replaces 0x40
    idle(32'h80);                                 push_lit(0, 32'h84, 3, 1);
    drive(32'h80, 1, 32'h80, 1, 32'h200, 0);     push_lit(0, 32'h84, 3, 1);
    idle(32'h80);                                 push_lit(1, 32'h200, 4, 1);
    idle(32'h40);                                 push_lit(0, 32'h44, 4, 1);
    // Saturation: allocate + three more taken -> 11, then not-taken -> 10
    drive(32'h40, 1, 32'h40, 1, 32'h300, 0);     push_lit(0, 32'h44, 4, 1);
    drive(32'h40, 1, 32'h40, 1, 32'h300, 0);     push_lit(1, 32'h300, 5, 1);
    drive(32'h40, 1, 32'h40, 1, 32'h300, 0);     push_lit(1, 32'h300, 6, 1);
    drive(32'h40, 1, 32'h40, 1, 32'h300, 0);     push_lit(1, 32'h300, 7, 1);
    drive(32'h40, 1, 32'h40, 0, 32'h0, 0);       push_lit(1, 32'h300, 8, 1);
    drive(32'h40, 1, 32'h40, 0, 32'h0, 0);       push_lit(1, 32'h300, 9, 1);
    idle(32'h40);                                 push_lit(0, 32'h44, 10, 1);
    // update_valid=0 ignores every other update input
    drive(32'h40, 0, 32'h40, 1, 32'h500, 1);     push_lit(0, 32'h44, 10, 1);
    idle(32'h40);                                 push_lit(0, 32'h44, 10, 1);
    // Not-taken miss does not allocate
    drive(32'hC0, 1, 32'hC0, 0, 32'h0, 0);       push_lit(0, 32'hC4, 10, 1);
    idle(32'hC0);                                 push_lit(0, 32'hC4, 11, 1);
    // Another index, with mispredict
    drive(32'h44, 1, 32'h44, 1, 32'h700, 1);     push_lit(0, 32'h48, 11, 1);
    idle(32'h44);                                 push_lit(1, 32'h700, 12, 2);
    idle(32'h40);                                 push_lit(0, 32'h44, 12, 2);
    idle(32'h80);                                 push_lit(0, 32'h84, 12, 2);
    // Top-of-address PC: target wraps mod 2^32
    drive(32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0, 0); push_lit(0, 32'h0, 12, 2);
    idle(32'h44);                                 push_lit(1, 32'h700, 13, 2);

    // Reset mid-cycle: outputs drop within the cycle; update under reset is dropped
    @(posedge clock);
    #2;
    reset                 = 1'b1;
    bus.pc_in             = 32'h44;
    bus.update_valid      = 1'b1;
    bus.update_pc         = 32'h44;
    bus.update_taken      = 1'b1;
    bus.update_target     = 32'h900;
    bus.update_mispredict = 1'b1;
    push_lit(0, 32'h48, 0, 0);
    @(posedge clock);
    #2;
    reset            = 1'b0;
    bus.update_valid = 1'b0;
    push_lit(0, 32'h48, 0, 0);
    idle(32'h44);                                 push_lit(0, 32'h48, 0, 0);

    // Statistics saturation: 65537 mispredicted not-taken misses
    for (int n = 0; n < 65537; n++) begin
      drive(32'h40, 1, 32'h1000, 0, 32'h0, 1);
    end
    idle(32'h40);                                 push_lit(0, 32'h44, 16'hFFFF, 16'hFFFF);
    idle(32'h40);
    idle(32'h40);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL lit_queue_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, number of predictor entries; SHALL be a power of two, 2..256.
REQ-002 Parameter XLEN, default 32, address/data width.
REQ-003 Parameter CNT_W, default 16, width of each statistics counter.
REQ-004 Derived constant IDX = log2(ENTRIES); index = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2].
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clock  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 pc_in  input  XLEN  fetch-stage PC to predict.
REQ-009 predict_taken  output  1  predicted direction for pc_in.
REQ-010 predict_target  output  XLEN  predicted next PC for pc_in.
REQ-011 update_valid  input  1  resolved branch present this cycle.
REQ-012 update_pc  input  XLEN  PC of resolved branch.
REQ-013 update_taken  input  1  actual branch outcome.
REQ-014 update_target  input  XLEN  actual branch target.
REQ-015 update_mispredict  input  1  pipeline flushed for this branch.
REQ-016 branch_count  output  CNT_W  resolved branches since reset.
REQ-017 mispredict_count  output  CNT_W  mispredicted branches since reset.

Function
REQ-018 Each entry SHALL hold valid (1b), tag, target (XLEN), 2-bit saturating counter.
REQ-019 Lookup SHALL be combinational: hit = valid[index] and tag match on pc_in.
REQ-020 predict_taken SHALL equal hit and counter[1]; counter encoding 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-021 predict_target SHALL equal stored target when predict_taken=1, else pc_in+4 (mod 2^XLEN).
REQ-022 Update SHALL be applied on the rising clock edge with update_valid=1; lookup observes it from the next cycle.
REQ-023 Update hit, taken: counter increments saturating at 11; target overwritten with update_target.
REQ-024 Update hit, not taken: counter decrements saturating at 00; target unchanged.
REQ-025 Update miss, taken: entry allocated/replaced: valid=1, tag from update_pc, target=update_target, counter=10.
REQ-026 Update miss, not taken: entry SHALL remain unchanged (no allocation).
REQ-027 Same-cycle lookup and update to the same index SHALL return the pre-update entry contents (no bypass).
REQ-028 update_valid=0 SHALL leave all entries and counters unchanged regardless of other update inputs.
REQ-029 branch_count SHALL increment by 1 per update_valid cycle, saturating at all-ones.
REQ-030 mispredict_count SHALL increment by 1 when update_valid and update_mispredict, saturating at all-ones; update_mispredict ignored when update_valid=0.
REQ-031 Latency: prediction 0 cycles; update-to-visible 1 cycle; statistics visible 1 cycle after update.

Reset
REQ-032 While reset=1, all valid bits, counters, targets, and both statistics counters SHALL be 0 immediately, independent of clock.
REQ-033 Reset outputs: predict_taken=0, predict_target=pc_in+4, branch_count=0, mispredict_count=0.
REQ-034 Updates presented while reset=1 SHALL be discarded; first update accepted on first rising edge after reset deasserts.

Verification (ENTRIES=16, XLEN=32, CNT_W=16)
REQ-035 After reset, pc_in=0x40 -> predict_taken=0, predict_target=0x44, both counts 0.
REQ-036 Update pc 0x40 taken target 0x100 -> next cycle pc_in=0x40 gives taken=1, target 0x100, branch_count=1.
REQ-037 From REQ-036 state, two not-taken updates to 0x40 (mispredict=1 on first) -> counter 00, predict_taken=0, target 0x44, mispredict_count=1.
REQ-038 Alias: entry at 0x40 valid; pc_in=0x80 -> miss, target 0x84; taken update 0x80 target 0x200 -> 0x80 predicts 0x200, 0x40 now misses.
REQ-039 Saturation: four taken updates to 0x40 -> counter 11; one not-taken -> 10, still predicts taken; 65537 updates -> branch_count holds 0xFFFF.
REQ-040 Reset asserted mid-sequence between clock edges -> all outputs return to reset values within the same cycle; same-cycle lookup/update to one index returns old entry.
